// File: rtl/statemach1_pkg.sv
// statemach1_pkg: shared definitions for the statemach1 monitor.
//   STATE_W      width of the monitored state register
//   S0..S7       named state constants
//   ABSORBING    one-hot-per-state mask of states that hold forever (3, 6)
//   mon_state_t  monitor FSM encoding (IDLE: no previous sample, TRACK)
//   legal_step   1 when (from -> to) is an allowed transition
package statemach1_pkg;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S0 = 3'd0;
  localparam logic [STATE_W-1:0] S1 = 3'd1;
  localparam logic [STATE_W-1:0] S2 = 3'd2;
  localparam logic [STATE_W-1:0] S3 = 3'd3;
  localparam logic [STATE_W-1:0] S4 = 3'd4;
  localparam logic [STATE_W-1:0] S5 = 3'd5;
  localparam logic [STATE_W-1:0] S6 = 3'd6;
  localparam logic [STATE_W-1:0] S7 = 3'd7;

  // bit n set => state n is absorbing
  localparam logic [7:0] ABSORBING = 8'b0100_1000;

  typedef enum logic {MON_IDLE = 1'b0, MON_TRACK = 1'b1} mon_state_t;

  function automatic logic legal_step(input logic [STATE_W-1:0] from,
                                      input logic [STATE_W-1:0] to);
    logic ok;
    ok = 1'b0;
    case (from)
      S0: ok = (to == S1) || (to == S2);
      S1: ok = (to == S3) || (to == S4);
      S2: ok = (to == S6);
      S3: ok = (to == S3);
      S4: ok = (to == S5) || (to == S6);
      S5: ok = (to == S0);
      S6: ok = (to == S6);
      default: ok = 1'b0;  // nothing leaves 7
    endcase
    return ok;
  endfunction
endpackage

// File: rtl/statemach1_monitor_trace_fifo.sv
// trace_fifo: synchronous FIFO with registered pointers and occupancy count.
//   clk, rst     clock, async active-high reset (empties the FIFO)
//   i_push       write request; accepted when not full, or full with a pop
//   i_data       write data
//   i_pop        read request; ignored when empty
//   o_data       head entry, 0 while empty
//   o_empty      no entries held
//   o_full       DEPTH entries held
// No bypass: a push into an empty FIFO becomes visible the next cycle.
module trace_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_pop, w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FULL_CNT);
  assign w_pop   = i_pop && !o_empty;
  // a same-cycle pop frees the slot a full-FIFO push needs
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/statemach1_monitor.sv
// statemach1_monitor: passive checker / trace recorder for the statemach1
// state register.
//   clk, rst           clock, async active-high reset
//   state              monitored state, sampled every edge
//   rd_ready           host accepts the head trace entry
//   rd_valid/rd_data   trace entry {from, to} of each observed state change
//   steps              saturating count of state changes
//   done               combinational: state is absorbing (3/6) while tracking
//   err, err_from/to   sticky flag plus first illegal transition
//   ovf                sticky flag: a change was dropped on a full FIFO
module statemach1_monitor
  import statemach1_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         state,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [5:0]         rd_data,
  output logic [CNT_W-1:0]   steps,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_from,
  output logic [2:0]         err_to,
  output logic               ovf
);
  mon_state_t         r_mon, w_mon_nxt;
  logic [STATE_W-1:0] r_prev;
  logic               r_err;
  logic [STATE_W-1:0] r_err_from, r_err_to;
  logic [CNT_W-1:0]   r_steps;
  logic               r_ovf;

  logic w_track, w_change, w_illegal, w_pop, w_empty, w_full, w_drop;

  assign w_track   = (r_mon == MON_TRACK);
  assign w_change  = w_track && (state != r_prev);
  assign w_illegal = w_track && !legal_step(r_prev, state);
  assign w_pop     = rd_valid && rd_ready;
  assign w_drop    = w_change && w_full && !w_pop;

  // IDLE only covers the first edge after reset; TRACK holds until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_mon <= MON_IDLE;
    else     r_mon <= w_mon_nxt;
  end

  always_comb begin
    w_mon_nxt = r_mon;
    case (r_mon)
      MON_IDLE:  w_mon_nxt = MON_TRACK;
      MON_TRACK: w_mon_nxt = MON_TRACK;
      default:   w_mon_nxt = MON_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev     <= '0;
      r_err      <= 1'b0;
      r_err_from <= '0;
      r_err_to   <= '0;
      r_steps    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_prev <= state;
      if (w_illegal && !r_err) begin
        r_err      <= 1'b1;
        r_err_from <= r_prev;
        r_err_to   <= state;
      end
      if (w_change && (r_steps != '1)) r_steps <= r_steps + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  trace_fifo #(.W(6), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_change),
    .i_data  ({r_prev, state}),
    .i_pop   (w_pop),
    .o_data  (rd_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign rd_valid = !w_empty;
  assign done     = w_track && ABSORBING[state];
  assign steps    = r_steps;
  assign err      = r_err;
  assign err_from = r_err_from;
  assign err_to   = r_err_to;
  assign ovf      = r_ovf;
endmodule

// File: tb/tb_statemach1_monitor.sv
module tb_statemach1_monitor;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] state = '0;
  logic rd_ready = 1'b0;
  logic rd_valid, done, err, ovf;
  logic [5:0] rd_data;
  logic [CNT_W-1:0] steps;
  logic [2:0] err_from, err_to;

  int checks = 0, failures = 0;

  statemach1_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .state(state), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .steps(steps), .done(done),
    .err(err), .err_from(err_from), .err_to(err_to), .ovf(ovf));

  always #5 clk = ~clk;

  // ---- reference model (transaction level) ----
  logic [5:0] legal_pairs [10] = '{6'o01, 6'o02, 6'o13, 6'o14, 6'o26,
                                   6'o45, 6'o46, 6'o50, 6'o33, 6'o66};
  bit         m_track, m_err, m_ovf;
  logic [2:0] m_prev, m_efrom, m_eto;
  int         m_steps;
  logic [5:0] m_q[$];
  logic [5:0] got[$];   // entries the DUT handed over on handshakes

  function automatic bit is_legal(input logic [2:0] f, input logic [2:0] t);
    foreach (legal_pairs[i]) if (legal_pairs[i] == {f, t}) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_track = 0; m_err = 0; m_ovf = 0; m_prev = '0; m_efrom = '0; m_eto = '0;
    m_steps = 0; m_q.delete(); got.delete();
  endtask

  // drive one cycle starting just after an edge; model follows the edge
  task automatic cycle(input logic [2:0] st, input logic rdy);
    bit popping;
    int sz;
    state = st; rd_ready = rdy;
    #3;
    if (rd_valid && rd_ready) got.push_back(rd_data);
    @(posedge clk);
    sz = m_q.size();
    popping = (sz > 0) && rdy;
    if (!m_track) begin
      m_track = 1;
    end else begin
      if (!is_legal(m_prev, st) && !m_err) begin
        m_err = 1; m_efrom = m_prev; m_eto = st;
      end
      if (st != m_prev) begin
        if (m_steps < (1 << CNT_W) - 1) m_steps++;
        if (popping) void'(m_q.pop_front());
        if (sz < DEPTH || popping) m_q.push_back({m_prev, st});
        else m_ovf = 1;
        popping = 0;
      end
      if (popping) void'(m_q.pop_front());
    end
    m_prev = st;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
  endtask

  // ---- tests ----
  task automatic test_reset();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL reset_rd_data got=%o exp=0", rd_data); end
    checks++; if (steps !== '0) begin failures++; $display("FAIL reset_steps got=%0d exp=0", steps); end
    checks++; if ({done, err, ovf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, err, ovf}); end
    checks++; if ({err_from, err_to} !== 6'd0) begin failures++; $display("FAIL reset_errcap got=%o exp=0", {err_from, err_to}); end
  endtask

  task automatic test_legal_walk();
    logic [2:0] seq [9] = '{0, 1, 4, 5, 0, 2, 6, 6, 6};
    logic [5:0] exp_e [6] = '{6'o01, 6'o14, 6'o45, 6'o50, 6'o02, 6'o26};
    do_reset();
    foreach (seq[i]) begin
      cycle(seq[i], 1'b1);
      checks++; if (done !== (i >= 6)) begin failures++; $display("FAIL walk_done i=%0d got=%b exp=%b", i, done, i >= 6); end
    end
    checks++; if (got.size() != 6) begin failures++; $display("FAIL walk_count got=%0d exp=6", got.size()); end
    foreach (exp_e[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_e[i]) begin failures++; $display("FAIL walk_entry%0d got=%o exp=%o", i, got[i], exp_e[i]); end
    end
    checks++; if (steps !== 16'd6 || err !== 1'b0) begin failures++; $display("FAIL walk_steps_err got=%0d/%b exp=6/0", steps, err); end
  endtask

  task automatic test_illegal();
    do_reset();
    cycle(0, 1); cycle(1, 1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_pre got=%b exp=0", err); end
    cycle(2, 1);
    checks++; if ({err, err_from, err_to} !== {1'b1, 3'd1, 3'd2}) begin failures++; $display("FAIL ill_capture got=%b/%0d/%0d exp=1/1/2", err, err_from, err_to); end
    cycle(3, 1);
    checks++; if ({err, err_from, err_to} !== {1'b1, 3'd1, 3'd2}) begin failures++; $display("FAIL ill_keep got=%b/%0d/%0d exp=1/1/2", err, err_from, err_to); end
    checks++; if (steps !== 16'd3) begin failures++; $display("FAIL ill_steps got=%0d exp=3", steps); end
  endtask

  task automatic test_overflow();
    logic [2:0] seq [10] = '{0, 1, 4, 5, 0, 1, 4, 5, 0, 1};
    logic [5:0] exp_e [8] = '{6'o01, 6'o14, 6'o45, 6'o50, 6'o01, 6'o14, 6'o45, 6'o50};
    do_reset();
    foreach (seq[i]) cycle(seq[i], 1'b0);
    checks++; if (ovf !== 1'b1 || steps !== 16'd9) begin failures++; $display("FAIL ovf_flag got=%b/%0d exp=1/9", ovf, steps); end
    for (int k = 0; k < 12; k++) cycle(1, 1'b1);   // bounded drain
    checks++; if (got.size() != 8) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=8", got.size()); end
    foreach (exp_e[i]) if (i < got.size()) begin
      checks++; if (got[i] !== exp_e[i]) begin failures++; $display("FAIL ovf_entry%0d got=%o exp=%o", i, got[i], exp_e[i]); end
    end
  endtask

  task automatic test_full_pop();
    logic [2:0] seq [9] = '{0, 1, 4, 5, 0, 1, 4, 5, 0};
    do_reset();
    foreach (seq[i]) cycle(seq[i], 1'b0);
    cycle(1, 1'b1);   // push while full, with a pop
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%b exp=0", ovf); end
    checks++; if (rd_data !== 6'o14) begin failures++; $display("FAIL fullpop_head got=%o exp=14", rd_data); end
    got.delete();
    for (int k = 0; k < 12; k++) cycle(1, 1'b1);
    checks++; if (got.size() != 8) begin failures++; $display("FAIL fullpop_count got=%0d exp=8", got.size()); end
    checks++; if (got.size() == 8 && got[7] !== 6'o01) begin failures++; $display("FAIL fullpop_last got=%o exp=01", got[7]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(0, 0); cycle(2, 0); cycle(6, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(6, 0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 6'o02) begin failures++; $display("FAIL bp_hold%0d got=%b/%o exp=1/02", k, rd_valid, rd_data); end
    end
    cycle(6, 1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 6'o26) begin failures++; $display("FAIL bp_pop1 got=%b/%o exp=1/26", rd_valid, rd_data); end
    cycle(6, 0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 6'o26) begin failures++; $display("FAIL bp_after got=%b/%o exp=1/26", rd_valid, rd_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(0, 0); cycle(1, 0); cycle(2, 0); cycle(3, 0);
    checks++; if (err !== 1'b1 || m_q.size() != 3) begin failures++; $display("FAIL ar_setup got=%b exp=1", err); end
    rst = 1'b1; #1;
    checks++; if ({rd_valid, done, err, ovf} !== 4'b0 || steps !== '0 || rd_data !== '0 || {err_from, err_to} !== '0) begin
      failures++; $display("FAIL ar_immediate got=%b%b%b%b steps=%0d data=%o", rd_valid, done, err, ovf, steps, rd_data); end
    #1; rst = 1'b0; model_reset();
    cycle(7, 0);   // would be illegal from 0, but this edge only latches
    checks++; if (err !== 1'b0 || steps !== '0 || rd_valid !== 1'b0) begin failures++; $display("FAIL ar_first_edge got=%b/%0d/%b exp=0/0/0", err, steps, rd_valid); end
    cycle(7, 0);
    checks++; if (err !== 1'b1 || {err_from, err_to} !== 6'o77) begin failures++; $display("FAIL ar_second_edge got=%b/%o exp=1/77", err, {err_from, err_to}); end
  endtask

  task automatic test_random();
    logic [2:0] st;
    int r;
    do_reset();
    st = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) st = 3'($urandom_range(0, 7));
      else case (st)
        0: st = r[0] ? 3'd1 : 3'd2;
        1: st = r[0] ? 3'd3 : 3'd4;
        2: st = 3'd6;
        4: st = r[0] ? 3'd5 : 3'd6;
        5: st = 3'd0;
        3, 6: st = (r > 7) ? 3'd0 : st;
        default: st = 3'd0;
      endcase
      cycle(st, 1'($urandom_range(0, 2) != 0));
      checks++;
      if (rd_valid !== (m_q.size() > 0) || (m_q.size() > 0 && rd_data !== m_q[0]) ||
          steps !== CNT_W'(m_steps) || err !== m_err || ovf !== m_ovf ||
          (m_err && {err_from, err_to} !== {m_efrom, m_eto}) ||
          done !== (m_track && (st == 3 || st == 6))) begin
        failures++;
        $display("FAIL rand n=%0d got v=%b d=%o s=%0d e=%b%o o=%b dn=%b exp v=%b s=%0d e=%b%o o=%b",
                 n, rd_valid, rd_data, steps, err, {err_from, err_to}, ovf, done,
                 m_q.size() > 0, m_steps, m_err, {m_efrom, m_eto}, m_ovf);
      end
    end
  endtask

  initial begin
    model_reset();
    #3;
    test_reset();
    #4;   // settle just past the first edge before releasing reset
    test_legal_walk();
    test_illegal();
    test_overflow();
    test_full_pop();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/statemach1_monitor.md
# statemach1_monitor

Passive checker and trace recorder sitting directly downstream of the 3-bit `statemach1` state register, on the same clock. Each cycle it compares the sampled state with the previous sample, flags any transition outside the legal set, counts state changes, reports arrival in an absorbing state, and pushes every state change into a small trace FIFO that a host drains over a valid/ready port.

## Interface
- `DEPTH`, 8: trace FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the step counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  3  monitored state, sampled every cycle.
- `rd_ready`  in  1  host accepts the trace entry.
- `rd_valid`  out  1  trace entry available.
- `rd_data`  out  6  trace entry: {from[2:0], to[2:0]}.
- `steps`  out  CNT_W  count of observed state changes; saturates at all-ones.
- `done`  out  1  the monitored state sits in absorbing state 3 or 6.
- `err`  out  1  sticky illegal-transition flag.
- `err_from`, `err_to`  out  3 each  first illegal transition captured.
- `ovf`  out  1  sticky flag: a trace entry was dropped because the FIFO was full.

## Operation
- Monitor states: IDLE (no previous sample held) and TRACK.
  - Reset forces IDLE.
  - The first clock edge after reset release latches `state` into `prev` and moves to TRACK. No check is made on that edge.
  - TRACK is held until the next reset.
- Legal pairs (prev -> cur):
  - 0->1, 0->2
  - 1->3, 1->4
  - 2->6
  - 4->5, 4->6
  - 5->0
  - 3->3, 6->6 (absorbing holds)
  - Every other pair is illegal, including any self-hold of 0, 1, 2, 4 or 5, and anything into or out of 7.
- In TRACK, on each edge:
  - Evaluate (`prev`, `state`), then update `prev` to `state`.
  - If the pair is illegal and `err` is 0: set `err`, capture `err_from` and `err_to`.
  - Later illegal pairs do not overwrite the capture.
  - Checking continues after an error.
- State change means `prev != state`. On every state change, legal or not:
  - `steps` increments, saturating.
  - The entry {prev, state} is pushed to the FIFO.
- Holds (3->3, 6->6, or an illegal hold) push nothing and do not count.
- `done` is combinational: (`state` == 3 or `state` == 6) AND TRACK.
- FIFO rules:
  - A pop happens when `rd_valid` and `rd_ready` are both high.
  - `rd_valid` is high when the FIFO is non-empty, and `rd_data` shows the head entry.
  - While `rd_valid` is high and `rd_ready` is low, `rd_data` holds stable.
  - Push when full with no pop in the same cycle: the entry is dropped, `ovf` is set, `steps` still increments.
  - Push when full with a pop in the same cycle: the pop frees the slot, the push is accepted, `ovf` is unchanged.
  - Push and pop when empty: the push is accepted, and `rd_valid` rises on the following cycle (no bypass path).
- Reset values:
  - `rd_valid` = 0, `rd_data` = 0, `steps` = 0, `done` = 0.
  - `err` = 0, `err_from` = 0, `err_to` = 0, `ovf` = 0.
  - FIFO empty, `prev` = 0.
  - Reset mid-operation discards all entries and flags immediately (asynchronous).

## Timing
- Check latency: an illegal `state` value sampled at edge N gives `err` high after edge N, i.e. visible in cycle N+1.
- Trace latency: a change sampled at edge N raises `rd_valid` in cycle N+1 if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- A full FIFO sustains a push each cycle as long as `rd_ready` is held high.
- `done` has zero latency relative to `state`. It is the only combinational output.

## Structure
- Shared package `statemach1_pkg`:
  - `STATE_W` = 3
  - named state constants S0..S7
  - `ABSORBING` mask
  - function `legal_step(from, to)` implementing the pair list above
- Natural sub-module: `trace_fifo`, a synchronous FIFO parameterised on width and `DEPTH`, with registered pointers and a count. It provides full/empty and accepts push-while-full-with-pop.
- The top level holds `prev`, the IDLE/TRACK flag, the error capture and the step counter.

## Test plan
- Legal walk: reset, then drive 0,1,4,5,0,2,6,6,6 with `rd_ready` = 1 ->
  - entries 0->1, 1->4, 4->5, 5->0, 0->2, 2->6
  - `steps` = 6, `err` = 0
  - `done` high from the first cycle `state` = 6
- Illegal capture: drive 0,1,2,3 ->
  - `err` is set after the 1->2 sample with `err_from` = 1, `err_to` = 2
  - the later 2->3 does not overwrite the capture
  - `steps` = 3
- Overflow (`DEPTH` = 8, `rd_ready` = 0): drive 9 state changes ->
  - `ovf` = 1, `steps` = 9
  - draining yields exactly the first 8 entries in order
- Full with simultaneous pop: fill the FIFO to 8, then drive one more change with `rd_ready` = 1 in the same cycle -> `ovf` stays 0 and the count stays 8.
- Backpressure: hold `rd_ready` = 0 for 5 cycles with `rd_valid` = 1 -> `rd_data` stays stable, then a single handshake pops exactly one entry.
- Async reset mid-trace: assert `rst` between edges with 3 entries queued and `err` = 1 ->
  - all outputs return to their reset values immediately
  - the first post-reset edge only latches `prev` and raises no error
